// File: rtl/uart_frame_loader_if.sv
// Byte stream in, checked parameter frame out, plus status and error outputs.
// The master side drives bytes and params_ready. The slave side is the frame loader.
interface uart_frame_loader_if #(
  parameter int PARAM_BYTES = 26,
  parameter int CNT_WIDTH   = 8
);
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic [8*PARAM_BYTES-1:0] params;
  logic                     params_valid;
  logic                     params_ready;
  logic                     busy;
  logic                     crc_err;
  logic                     timeout_err;
  logic                     overflow;
  logic [CNT_WIDTH-1:0]     err_count;

  modport master (
    output rx_data, rx_valid, params_ready,
    input  params, params_valid, busy, crc_err, timeout_err, overflow, err_count
  );

  modport slave (
    input  rx_data, rx_valid, params_ready,
    output params, params_valid, busy, crc_err, timeout_err, overflow, err_count
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Parses frames of the form SYNC, payload (MSB first), checksum into a params register with a valid/ready handshake.
// Outputs are registered one cycle after the checksum byte. A good frame that arrives while params is still unconsumed is dropped and reported.
module uart_frame_loader #(
  parameter int          PARAM_BYTES    = 26,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 17360,
  parameter int          CNT_WIDTH      = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_frame_loader_if.slave bus
);

  localparam int IDX_W = (PARAM_BYTES > 1) ? $clog2(PARAM_BYTES) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PARAM_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam int PW = 8 * PARAM_BYTES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           sum_q, sum_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [PW-1:0]        shadow_q, shadow_d;
  logic [PW-1:0]        params_q, params_d;
  logic                 params_valid_q, params_valid_d;
  logic                 crc_err_q, crc_err_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [7:0]           chk_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      sum_q          <= '0;
      timer_q        <= '0;
      shadow_q       <= '0;
      params_q       <= '0;
      params_valid_q <= 1'b0;
      crc_err_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      overflow_q     <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      sum_q          <= sum_d;
      timer_q        <= timer_d;
      shadow_q       <= shadow_d;
      params_q       <= params_d;
      params_valid_q <= params_valid_d;
      crc_err_q      <= crc_err_d;
      timeout_err_q  <= timeout_err_d;
      overflow_q     <= overflow_d;
      err_count_q    <= err_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    sum_d          = sum_q;
    timer_d        = timer_q;
    shadow_d       = shadow_q;
    params_d       = params_q;
    params_valid_d = params_valid_q && !bus.params_ready;
    crc_err_d      = 1'b0;
    timeout_err_d  = 1'b0;
    overflow_d     = 1'b0;
    err_count_d    = err_count_q;
    chk_sum        = sum_q + bus.rx_data;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          state_d = PAYLOAD;
          idx_d   = IDX_TOP;
          sum_d   = '0;
          timer_d = '0;
        end
      end

      PAYLOAD: begin
        if (bus.rx_valid) begin
          for (int b = 0; b < PARAM_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) shadow_d[8*b +: 8] = bus.rx_data;
          end
          sum_d   = sum_q + bus.rx_data;
          timer_d = '0;
          if (idx_q == '0) state_d = CHECK;
          else             idx_d   = idx_q - 1'b1;
        end else if (timer_q == TMR_MAX) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      CHECK: begin
        if (bus.rx_valid) begin
          state_d = IDLE;
          timer_d = '0;
          if (chk_sum == 8'h00) begin
            // A consumer taking the old frame this cycle frees the slot for the new one.
            if (!params_valid_q || bus.params_ready) begin
              params_d       = shadow_q;
              params_valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            crc_err_d = 1'b1;
          end
        end else if (timer_q == TMR_MAX) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if ((crc_err_d || timeout_err_d || overflow_d) && err_count_q != {CNT_WIDTH{1'b1}})
      err_count_d = err_count_q + 1'b1;
  end

  assign bus.params       = params_q;
  assign bus.params_valid = params_valid_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.crc_err      = crc_err_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.overflow     = overflow_q;
  assign bus.err_count    = err_count_q;

endmodule
